fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 77 +++++++
 rtl/fetch_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'd0,
    FETCH_REQ     = 2'd1,
    FETCH_RELEASE = 2'd2
  } fetch_state_e;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer with flush; head read straight from
// the registered storage so decode never sees a same-cycle push.
module fetch_fifo #(
  parameter int WIDTH      = 64,
  parameter int DEPTH      = 4,
  parameter int LOG2_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [WIDTH-1:0]      head_data,
  output logic [LOG2_DEPTH:0]   count,
  output logic                  full
);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [WIDTH-1:0]      mem_d [DEPTH];
  logic [LOG2_DEPTH-1:0] head_q, head_d;
  logic [LOG2_DEPTH-1:0] tail_q, tail_d;
  logic [LOG2_DEPTH:0]   count_q, count_d;
  logic                  do_push, do_pop;

  function automatic logic [LOG2_DEPTH-1:0] ptr_inc(
    input logic [LOG2_DEPTH-1:0] p
  );
    if (p == LOG2_DEPTH'(DEPTH - 1))
      return '0;
    return p + LOG2_DEPTH'(1);
  endfunction

  assign full      = (count_q == (LOG2_DEPTH+1)'(DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[head_q];
  assign do_push   = push && !full;
  assign do_pop    = pop && (count_q != '0);

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_push)
      mem_d[tail_q] = push_data;
    // flush beats any push or pop in the same cycle
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push)
        tail_d = ptr_inc(tail_q);
      if (do_pop)
        head_d = ptr_inc(head_q);
      count_d = count_q
              + (LOG2_DEPTH+1)'(do_push)
              - (LOG2_DEPTH+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding cache request, redirect/flush, FIFO.
// Optional perf counters enabled by macro FETCH_PERF_CNT_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int WORD_WIDTH      = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int LOG2_FIFO_DEPTH = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC =
    ADDR_WIDTH'(FETCH_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  req,
  output logic [ADDR_WIDTH-1:0] addr,
  input  logic                  valid,
  input  logic [WORD_WIDTH-1:0] data,
  output logic                  instr_valid,
  output logic [WORD_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetch_count,
  output logic [31:0]           perf_stall_count
`endif
);

  localparam int EW = ADDR_WIDTH + WORD_WIDTH;

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  discard_q, discard_d;
  logic                  push, pop, flush;
  logic                  fifo_full;
  logic [EW-1:0]         head;
  logic [LOG2_FIFO_DEPTH:0] count;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    push      = 1'b0;
    flush     = redirect;
    unique case (state_q)
      FETCH_IDLE: begin
        if (redirect)
          pc_d = redirect_pc;
        else if (!fifo_full)
          state_d = FETCH_REQ;
      end
      FETCH_REQ: begin
        if (valid) begin
          state_d   = FETCH_RELEASE;
          discard_d = 1'b0;
          push      = !discard_q && !redirect;
          if (redirect)
            pc_d = redirect_pc;
          else if (!discard_q)
            pc_d = addr_q + ADDR_WIDTH'(1);
        end else if (redirect) begin
          // miss stays in flight; its word is dropped on return
          pc_d      = redirect_pc;
          discard_d = 1'b1;
        end
      end
      FETCH_RELEASE: begin
        state_d = FETCH_IDLE;
        if (redirect)
          pc_d = redirect_pc;
      end
      default: state_d = FETCH_IDLE;
    endcase
    addr_d = (state_q == FETCH_REQ) ? addr_q : pc_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH_IDLE;
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      discard_q <= discard_d;
    end
  end

  assign req         = (state_q == FETCH_REQ);
  assign addr        = addr_q;
  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready;
  assign instr       = head[WORD_WIDTH-1:0];
  assign instr_pc    = head[WORD_WIDTH +: ADDR_WIDTH];

  fetch_fifo #(
    .WIDTH      (EW),
    .DEPTH      (FIFO_DEPTH),
    .LOG2_DEPTH (LOG2_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({addr_q, data}),
    .pop       (pop),
    .flush     (flush),
    .head_data (head),
    .count     (count),
    .full      (fifo_full)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + 32'(push);
    stall_cnt_d = stall_cnt_q + 32'(req && !valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_count = fetch_cnt_q;
  assign perf_stall_count = stall_cnt_q;
`endif

endmodule
